// File: rtl/cdc_bus_sender.sv
// Purpose : source half of a toggle-handshake multi-bit CDC; holds one word stable on xferData and flags it with an xferReq toggle.
// Latency : word on xferData at the accept edge, xferReq toggles one edge later, dataReady returns SYNC_STAGES+1 edges after xferAck toggles.
// Backpr. : dataReady low from accept until the synchronized ack matches xferReq; dataValid is ignored in that window.
//
// Ports:
//   clk, rst_n              source clock, async active-low reset
//   dataIn/dataValid/dataReady   valid/ready input stream
//   xferData/xferReq        registered bus + request toggle to the destination
//   xferAck                 asynchronous acknowledge toggle from the destination
//   busy                    transfer outstanding (LOAD or WAIT_ACK)
//   timeoutPulse/Flag       WAIT_ACK timeout event / sticky status
//   protoErr                sticky: ack moved while no request was outstanding
//   clearStatus             synchronous clear of the sticky flags (a new set wins)
module cdc_bus_sender #(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,     // 2..4
    parameter int TIMEOUT_CYCLES = 1024   // 0 disables, max 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  dataValid,
    output logic                  dataReady,
    output logic [DATA_WIDTH-1:0] xferData,
    output logic                  xferReq,
    input  logic                  xferAck,
    output logic                  busy,
    output logic                  timeoutPulse,
    output logic                  timeoutFlag,
    output logic                  protoErr,
    input  logic                  clearStatus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0]    TO_LAST = 16'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    req_q, req_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    to_pulse_q, to_pulse_d;
    logic                    to_flag_q, to_flag_d;
    logic                    perr_q, perr_d;
    logic                    ack_prev_q;

    (* ASYNC_REG = "TRUE" *) (* keep = "true" *)
    logic [SYNC_STAGES-1:0]  ack_sync_q;

    logic ack_s;
    logic ack_match;
    logic ack_moved;
    logic perr_set;
    logic to_set;

    assign ack_s     = ack_sync_q[SYNC_STAGES-1];
    assign ack_match = (ack_s == req_q);
    // ack_prev_q trails ack_s by one cycle, so any change of the synchronized
    // ack shows up here for exactly one cycle.
    assign ack_moved = ack_s ^ ack_prev_q;
    assign perr_set  = ack_moved && (state_q != WAIT_ACK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            req_q      <= 1'b0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            to_pulse_q <= 1'b0;
            to_flag_q  <= 1'b0;
            perr_q     <= 1'b0;
            ack_prev_q <= 1'b0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            to_pulse_q <= to_pulse_d;
            to_flag_q  <= to_flag_d;
            perr_q     <= perr_d;
            ack_prev_q <= ack_s;
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], xferAck};
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        to_set     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // ready_q gates the accept so the first edge after reset
                // only raises dataReady.
                if (dataValid && ready_q) begin
                    data_d  = dataIn;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Data has been stable for a full cycle before the toggle.
                req_d   = ~req_q;
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_match) begin
                    state_d = IDLE;
                end else if (TO_EN) begin
                    // Counter runs one past TO_LAST and then holds, so the
                    // timeout fires once per transfer.
                    if (cnt_q <= TO_LAST) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    to_set = (cnt_q == TO_LAST);
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d    = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        to_pulse_d = to_set;

        to_flag_d = to_flag_q;
        perr_d    = perr_q;
        if (clearStatus) begin
            to_flag_d = 1'b0;
            perr_d    = 1'b0;
        end
        if (to_set) begin
            to_flag_d = 1'b1;
        end
        if (perr_set) begin
            perr_d = 1'b1;
        end
    end

    assign dataReady    = ready_q;
    assign xferData     = data_q;
    assign xferReq      = req_q;
    assign busy         = busy_q;
    assign timeoutPulse = to_pulse_q;
    assign timeoutFlag  = to_flag_q;
    assign protoErr     = perr_q;

endmodule

// File: tb/tb_cdc_bus_sender.sv
// Bench for cdc_bus_sender: scoreboard of accepted words checked at each
// xferReq toggle, plus a simple destination model that acks 3 cycles later.
module tb_cdc_bus_sender;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] dataIn;
    logic       dataValid;
    logic       dataReady;
    logic [7:0] xferData;
    logic       xferReq;
    logic       xferAck;
    logic       busy;
    logic       timeoutPulse;
    logic       timeoutFlag;
    logic       protoErr;
    logic       clearStatus;

    always #5 clk = ~clk;

    cdc_bus_sender #(
        .DATA_WIDTH     (8),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dataIn       (dataIn),
        .dataValid    (dataValid),
        .dataReady    (dataReady),
        .xferData     (xferData),
        .xferReq      (xferReq),
        .xferAck      (xferAck),
        .busy         (busy),
        .timeoutPulse (timeoutPulse),
        .timeoutFlag  (timeoutFlag),
        .protoErr     (protoErr),
        .clearStatus  (clearStatus)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         tick_n = 0;
    int         ack_tick = 0;
    int         ack_cnt = 0;
    int         req_toggles = 0;
    int         pulse_cnt = 0;
    int         pulse_tick = 0;
    bit         auto_ack = 1'b1;
    logic       req_prev = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: sample #1 after the edge, run the monitor and destination model.
    task automatic tick();
        @(posedge clk);
        #1;
        tick_n++;
        if (timeoutPulse) begin
            pulse_cnt++;
            pulse_tick = tick_n;
        end
        if (xferReq !== req_prev) begin
            req_toggles++;
            req_prev = xferReq;
            if (exp_q.size() == 0) check("unexpected_req", 32'(xferData), 32'hDEAD);
            else                   check("xfer_data", 32'(xferData), 32'(exp_q.pop_front()));
            if (auto_ack) ack_cnt = 3;
        end else if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) begin
                xferAck  = xferReq;
                ack_tick = tick_n;
            end
        end
    endtask

    task automatic wait_ready(output int t);
        bit found = 1'b0;
        t = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (dataReady) begin
                found = 1'b1;
                t = tick_n;
            end
        end
        if (!found) check("ready_wait", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] w);
        dataIn    = w;
        dataValid = 1'b1;
        exp_q.push_back(w);
        tick();
        dataValid = 1'b0;
    endtask

    initial begin
        int t_rdy;
        int t0;
        int enter;
        int toggles0;

        rst_n = 1'b0; dataIn = '0; dataValid = 1'b0; xferAck = 1'b0; clearStatus = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(dataReady), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_req",   32'(xferReq),   32'd0);
        check("rst_data",  32'(xferData),  32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("ready_after_rst", 32'(dataReady), 32'd1);
        check("busy_after_rst",  32'(busy),      32'd0);

        // First word: A5, then hold valid with changing data while busy.
        send(8'hA5);
        check("a5_data_at_k", 32'(xferData),  32'hA5);
        check("a5_busy",      32'(busy),      32'd1);
        check("a5_not_ready", 32'(dataReady), 32'd0);
        check("a5_req_k",     32'(xferReq),   32'd0);
        tick();
        check("a5_req_k1",    32'(xferReq),   32'd1);
        t_rdy = 0;
        for (int i = 0; i < 40 && t_rdy == 0; i++) begin
            dataIn    = (i == 0) ? 8'hFF : 8'($urandom);
            dataValid = 1'b1;
            tick();
            if (dataReady) t_rdy = tick_n;
            else           check("hold_a5", 32'(xferData), 32'hA5);
        end
        dataValid = 1'b0;
        check("ready_seen",     32'(t_rdy != 0),        32'd1);
        check("ready_lat",      32'(t_rdy - ack_tick),  32'd3);
        check("one_toggle",     32'(req_toggles),       32'd1);
        check("a5_busy_done",   32'(busy),              32'd0);
        check("a5_data_persist",32'(xferData),          32'hA5);

        // Second word toggles the request back to 0.
        send(8'h3C);
        tick();
        check("3c_req", 32'(xferReq), 32'd0);
        wait_ready(t_rdy);
        check("3c_ready_lat", 32'(t_rdy - ack_tick), 32'd3);
        check("no_timeout",   32'(timeoutFlag),      32'd0);

        // Timeout: no ack from the destination.
        auto_ack  = 1'b0;
        pulse_cnt = 0;
        send(8'h5A);
        tick();
        enter = tick_n;
        check("5a_req", 32'(xferReq), 32'd1);
        repeat (30) tick();
        check("to_pulse_once", 32'(pulse_cnt),          32'd1);
        check("to_pulse_time", 32'(pulse_tick - enter), 32'd16);
        check("to_flag",       32'(timeoutFlag),        32'd1);
        check("to_still_busy", 32'(busy),               32'd1);
        xferAck = xferReq;
        ack_tick = tick_n;
        wait_ready(t_rdy);
        check("to_late_ack_lat", 32'(t_rdy - ack_tick), 32'd3);
        check("to_flag_sticky",  32'(timeoutFlag),      32'd1);
        clearStatus = 1'b1;
        tick();
        clearStatus = 1'b0;
        check("to_flag_clear",   32'(timeoutFlag),      32'd0);
        check("to_pulse_total",  32'(pulse_cnt),        32'd1);

        // Protocol error: ack moves while IDLE.
        toggles0 = req_toggles;
        xferAck = ~xferAck;
        t0 = tick_n;
        tick(); tick();
        check("perr_early", 32'(protoErr), 32'd0);
        tick();
        check("perr_set",   32'(protoErr), 32'd1);
        check("perr_idle",  32'(dataReady & ~busy), 32'd1);
        check("perr_noreq", 32'(req_toggles - toggles0), 32'd0);
        check("perr_edges", 32'(tick_n - t0), 32'd3);
        // Second error lands on the same edge as clearStatus: set wins.
        xferAck = ~xferAck;
        tick(); tick();
        clearStatus = 1'b1;
        tick();
        clearStatus = 1'b0;
        check("perr_set_wins", 32'(protoErr), 32'd1);
        clearStatus = 1'b1;
        tick();
        clearStatus = 1'b0;
        check("perr_clear", 32'(protoErr), 32'd0);

        // Reset in the middle of WAIT_ACK.
        send(8'h77);
        tick();
        tick(); tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req",   32'(xferReq),   32'd0);
        check("arst_data",  32'(xferData),  32'd0);
        check("arst_busy",  32'(busy),      32'd0);
        check("arst_ready", 32'(dataReady), 32'd0);
        xferAck  = 1'b0;
        req_prev = 1'b0;
        ack_cnt  = 0;
        auto_ack = 1'b1;
        tick();
        #2 rst_n = 1'b1;
        tick();
        check("ready_after_arst", 32'(dataReady), 32'd1);
        toggles0 = req_toggles;
        send(8'h01);
        wait_ready(t_rdy);
        check("01_toggled",  32'(req_toggles - toggles0), 32'd1);
        check("01_req",      32'(xferReq),   32'd1);
        check("01_perr",     32'(protoErr),  32'd0);
        check("sb_empty",    32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
